// File: rtl/bp_be_pipe_sys_ctrl.sv
// System-pipe controller: delays system/CSR metadata to commit, runs the PTW request FSM
// and gates interrupts. Define BP_BE_PIPE_SYS_PERF_EN to add PTW request/wait counters.
module bp_be_pipe_sys_ctrl #(
  parameter int vaddr_width_p   = 39,
  parameter int instr_width_p   = 32,
  parameter int csr_cmd_width_p = 80,
  parameter int stages_p        = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       sys_v_i,
  input  logic                       poison_i,
  input  logic                       store_i,
  input  logic                       csr_v_i,
  input  logic [csr_cmd_width_p-1:0] csr_cmd_i,
  input  logic [vaddr_width_p-1:0]   pc_i,
  input  logic [vaddr_width_p-1:0]   vaddr_i,
  input  logic [instr_width_p-1:0]   instr_i,
  input  logic                       flush_i,
  input  logic                       commit_v_i,
  input  logic                       itlb_miss_i,
  input  logic                       dtlb_miss_i,
  output logic                       ptw_req_v_o,
  input  logic                       ptw_req_ready_i,
  output logic [1:0]                 ptw_req_type_o,
  output logic [vaddr_width_p-1:0]   ptw_req_vaddr_o,
  output logic [vaddr_width_p-1:0]   ptw_req_pc_o,
  input  logic                       ptw_fill_v_i,
  input  logic                       ptw_fault_i,
  output logic                       page_fault_v_o,
  output logic [1:0]                 page_fault_type_o,
  output logic [vaddr_width_p-1:0]   exc_pc_o,
  output logic [vaddr_width_p-1:0]   exc_vaddr_o,
  output logic [instr_width_p-1:0]   exc_instr_o,
  output logic                       csr_cmd_v_o,
  output logic [csr_cmd_width_p-1:0] csr_cmd_o,
  output logic                       sys_v_o,
  input  logic                       interrupt_ready_i,
  input  logic                       mem_ready_i,
  input  logic                       long_ready_i,
  output logic                       interrupt_v_o,
  output logic                       ready_o
`ifdef BP_BE_PIPE_SYS_PERF_EN
  ,
  output logic [31:0]                ptw_req_count_o,
  output logic [31:0]                ptw_wait_cycles_o
`endif
);

  localparam int LAST = stages_p - 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  logic [stages_p-1:0]                      sys_v_q, sys_v_d, csr_v_q, csr_v_d, store_q, store_d;
  logic [stages_p-1:0][vaddr_width_p-1:0]   pc_q, pc_d, va_q, va_d;
  logic [stages_p-1:0][instr_width_p-1:0]   instr_q, instr_d;
  logic [stages_p-1:0][csr_cmd_width_p-1:0] cmd_q, cmd_d;

  state_e                   state_q, state_d;
  logic [1:0]               type_q, type_d;
  logic [vaddr_width_p-1:0] req_va_q, req_va_d, req_pc_q, req_pc_d;
  logic                     miss;

  // A killed instruction also drops its CSR command; flush drops same-cycle dispatch too.
  always_comb begin
    sys_v_d    = '0;
    csr_v_d    = '0;
    store_d    = store_q;
    pc_d       = pc_q;
    va_d       = va_q;
    instr_d    = instr_q;
    cmd_d      = cmd_q;
    sys_v_d[0] = sys_v_i & ~poison_i & ~flush_i;
    csr_v_d[0] = csr_v_i & sys_v_i & ~poison_i & ~flush_i;
    store_d[0] = store_i;
    pc_d[0]    = pc_i;
    va_d[0]    = vaddr_i;
    instr_d[0] = instr_i;
    cmd_d[0]   = csr_cmd_i;
    for (int i = 1; i < stages_p; i++) begin
      sys_v_d[i] = sys_v_q[i-1] & ~flush_i;
      csr_v_d[i] = csr_v_q[i-1] & ~flush_i;
      store_d[i] = store_q[i-1];
      pc_d[i]    = pc_q[i-1];
      va_d[i]    = va_q[i-1];
      instr_d[i] = instr_q[i-1];
      cmd_d[i]   = cmd_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sys_v_q <= '0;
      csr_v_q <= '0;
      store_q <= '0;
    end else begin
      sys_v_q <= sys_v_d;
      csr_v_q <= csr_v_d;
      store_q <= store_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pc_q    <= pc_d;
    va_q    <= va_d;
    instr_q <= instr_d;
    cmd_q   <= cmd_d;
  end

  assign sys_v_o     = sys_v_q[LAST];
  assign exc_pc_o    = pc_q[LAST];
  assign exc_vaddr_o = va_q[LAST];
  assign exc_instr_o = instr_q[LAST];
  assign csr_cmd_o   = cmd_q[LAST];
  assign csr_cmd_v_o = csr_v_q[LAST] & commit_v_i;

  assign miss = commit_v_i & (itlb_miss_i | dtlb_miss_i);

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    req_va_d = req_va_q;
    req_pc_d = req_pc_q;
    case (state_q)
      S_IDLE: if (miss) begin
        state_d  = S_REQ;
        req_pc_d = pc_q[LAST];
        if (itlb_miss_i) begin
          type_d   = 2'b00;
          req_va_d = pc_q[LAST];
        end else begin
          type_d   = store_q[LAST] ? 2'b10 : 2'b01;
          req_va_d = va_q[LAST];
        end
      end
      S_REQ:   if (ptw_req_ready_i) state_d = S_WAIT;
      S_WAIT:  if (ptw_fill_v_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      type_q   <= 2'b00;
      req_va_q <= '0;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      req_va_q <= req_va_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign ptw_req_v_o       = (state_q == S_REQ);
  assign ptw_req_type_o    = type_q;
  assign ptw_req_vaddr_o   = req_va_q;
  assign ptw_req_pc_o      = req_pc_q;
  assign page_fault_v_o    = (state_q == S_WAIT) & ptw_fill_v_i & ptw_fault_i;
  assign page_fault_type_o = type_q;
  assign ready_o           = (state_q == S_IDLE) & ~interrupt_ready_i;
  assign interrupt_v_o     = interrupt_ready_i & mem_ready_i & long_ready_i & ~commit_v_i
                           & (state_q == S_IDLE);

  // Misses are only legal while idle; ready_o is what keeps them out.
  miss_while_busy: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(miss && state_q != S_IDLE));

`ifdef BP_BE_PIPE_SYS_PERF_EN
  logic [31:0] req_cnt_q, req_cnt_d, wait_cnt_q, wait_cnt_d;

  always_comb begin
    req_cnt_d  = req_cnt_q;
    wait_cnt_d = wait_cnt_q;
    if (ptw_req_v_o && ptw_req_ready_i && req_cnt_q != '1) req_cnt_d = req_cnt_q + 32'd1;
    if (state_q != S_IDLE && wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      req_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      req_cnt_q  <= req_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign ptw_req_count_o   = req_cnt_q;
  assign ptw_wait_cycles_o = wait_cnt_q;
`endif

endmodule
